pwm_hw_detect: RTL

- Hardware pulse-width detector that measures the PWM waveform produced by the AXI Timer's pwm0 output and reports it back to software.
- Counts `sysclk` cycles spent high and low on `pwm_in` and latches one complete high/low pair per PWM period.
- Publishes the latched counts to the Microblaze GPIO/register interface.
- Sits inside EMBSYS on the `pwm_in` net; it is the receiving end of the timer's PWM output.

---
 rtl/pwm_hw_detect.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pwm_hw_detect.sv
// Pulse-width detector: measures the high and low time of an asynchronous PWM input in
// sysclk cycles and publishes one complete high/low/period triple per PWM period.
module pwm_hw_detect #(
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic                 sysclk,
    input  logic                 sysreset,
    input  logic                 pwm_in,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] high_count,
    output logic [CNT_WIDTH-1:0] low_count,
    output logic [CNT_WIDTH-1:0] period_count,
    output logic                 sample_valid,
    output logic                 stuck,
    output logic                 stuck_level
);

    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAlign, StMeasHigh, StMeasLow} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_d;
    logic [CNT_WIDTH-1:0]   r_hi_cnt;
    logic [CNT_WIDTH-1:0]   r_lo_cnt;
    logic [IdleW-1:0]       r_idle_cnt;
    logic [CNT_WIDTH-1:0]   r_high_count;
    logic [CNT_WIDTH-1:0]   r_low_count;
    logic [CNT_WIDTH-1:0]   r_period_count;
    logic                   r_sample_valid;
    logic                   r_stuck;
    logic                   r_stuck_level;

    logic                   w_pwm_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;
    logic                   w_active;
    logic                   w_timeout;
    logic [CNT_WIDTH-1:0]   w_hi_inc;
    logic [CNT_WIDTH-1:0]   w_lo_inc;
    logic [CNT_WIDTH:0]     w_sum;
    logic [CNT_WIDTH-1:0]   w_period;

    assign w_pwm_s   = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_pwm_s & ~r_pwm_d;
    assign w_fall    = ~w_pwm_s & r_pwm_d;
    assign w_edge    = w_rise | w_fall;
    assign w_active  = (r_state != StIdle);
    // An edge in the same cycle as the timeout takes priority.
    assign w_timeout = w_active && !w_edge && (r_idle_cnt == IdleLast);

    assign w_hi_inc  = (r_hi_cnt == CntMax) ? r_hi_cnt : r_hi_cnt + 1'b1;
    assign w_lo_inc  = (r_lo_cnt == CntMax) ? r_lo_cnt : r_lo_cnt + 1'b1;
    assign w_sum     = {1'b0, r_hi_cnt} + {1'b0, r_lo_cnt};
    assign w_period  = w_sum[CNT_WIDTH] ? CntMax : w_sum[CNT_WIDTH-1:0];

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:     w_state_next = StAlign;
                StAlign:    if (w_rise) w_state_next = StMeasHigh;
                StMeasHigh: begin
                    if (w_fall)         w_state_next = StMeasLow;
                    else if (w_timeout) w_state_next = StAlign;
                end
                StMeasLow: begin
                    if (w_rise)         w_state_next = StMeasHigh;
                    else if (w_timeout) w_state_next = StAlign;
                end
                default:    w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_sync         <= '0;
            r_pwm_d        <= 1'b0;
            r_hi_cnt       <= '0;
            r_lo_cnt       <= '0;
            r_idle_cnt     <= '0;
            r_high_count   <= '0;
            r_low_count    <= '0;
            r_period_count <= '0;
            r_sample_valid <= 1'b0;
            r_stuck        <= 1'b0;
            r_stuck_level  <= 1'b0;
        end else begin
            r_sync         <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_pwm_d        <= w_pwm_s;
            r_sample_valid <= 1'b0;
            if (enable) begin
                unique case (r_state)
                    StAlign: begin
                        if (w_rise) r_hi_cnt <= CNT_WIDTH'(1);
                    end
                    StMeasHigh: begin
                        if (w_fall) r_lo_cnt <= CNT_WIDTH'(1);
                        else        r_hi_cnt <= w_hi_inc;
                    end
                    StMeasLow: begin
                        if (w_rise) begin
                            r_high_count   <= r_hi_cnt;
                            r_low_count    <= r_lo_cnt;
                            r_period_count <= w_period;
                            r_sample_valid <= 1'b1;
                            r_hi_cnt       <= CNT_WIDTH'(1);
                        end else begin
                            r_lo_cnt <= w_lo_inc;
                        end
                    end
                    default: ;
                endcase
            end
            // Edge watchdog runs only while measuring; IDLE freezes stuck.
            if (enable && w_active) begin
                if (w_edge) begin
                    r_idle_cnt <= '0;
                    r_stuck    <= 1'b0;
                end else if (w_timeout) begin
                    r_idle_cnt    <= '0;
                    r_stuck       <= 1'b1;
                    r_stuck_level <= w_pwm_s;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign high_count   = r_high_count;
    assign low_count    = r_low_count;
    assign period_count = r_period_count;
    assign sample_valid = r_sample_valid;
    assign stuck        = r_stuck;
    assign stuck_level  = r_stuck_level;

endmodule
